// File: rtl/reaction_round_controller.sv
// Reaction-timer round sequencer: random wait, stimulus lamp, timing, false-start/timeout, best time.
// Optional macro LAST_TIME_EN adds the LastTime output holding the most recent valid reaction time.
module reaction_round_controller #(
  parameter int unsigned MIN_DELAY = 50,
  parameter int unsigned WAIT_W    = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Tick,
  input  logic        Start,
  input  logic        Stop,
  input  logic [6:0]  RandVal,
  input  logic [11:0] BcdIn,
  output logic        RandEn,
  output logic        CountClear,
  output logic        CountEn,
  output logic        LED,
  output logic        Foul,
  output logic [11:0] BestTime,
  output logic [3:0]  RoundCount,
`ifdef LAST_TIME_EN
  output logic [11:0] LastTime,
`endif
  output logic [2:0]  State
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned RND_W = 4;
  localparam int unsigned ST_W  = 3;
  localparam logic [BCD_W-1:0] BCD_MAX = BCD_W'(12'h999);
  localparam logic [RND_W-1:0] RND_MAX = RND_W'(15);

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GO   = 3'd2,
    DONE = 3'd3,
    FOUL = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [WAIT_W-1:0]  wait_q, wait_n, wait_load;
  logic               start_d, stop_d;
  logic               start_edge, stop_edge;
  logic [BCD_W-1:0]   best_n;
  logic [RND_W-1:0]   rounds_n;
  logic               count_en_n;
`ifdef LAST_TIME_EN
  logic [BCD_W-1:0]   last_n;
`endif

  assign State = ST_W'(state_q);

  // Next-state and next-value logic; Stop rules take priority over Start in every state.
  always_comb begin
    state_n    = state_q;
    wait_n     = wait_q;
    best_n     = BestTime;
    rounds_n   = RoundCount;
    count_en_n = 1'b0;
`ifdef LAST_TIME_EN
    last_n     = LastTime;
`endif
    start_edge = Start & ~start_d;
    stop_edge  = Stop & ~stop_d;
    wait_load  = WAIT_W'(MIN_DELAY) + WAIT_W'(RandVal);

    unique case (state_q)
      IDLE, DONE, FOUL: begin
        if (start_edge) begin
          state_n = ARM;
          wait_n  = wait_load;
        end
      end
      ARM: begin
        if (stop_edge) begin
          state_n = FOUL;
        end else if (Tick) begin
          wait_n = wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) state_n = GO;
        end
      end
      GO: begin
        count_en_n = Tick & ~stop_edge;
        if (stop_edge) begin
          state_n = DONE;
          if (BcdIn < BestTime) best_n = BcdIn;
          if (RoundCount != RND_MAX) rounds_n = RoundCount + RND_W'(1);
`ifdef LAST_TIME_EN
          last_n = BcdIn;
`endif
        end else if (Tick && (BcdIn == BCD_MAX)) begin
          state_n = FOUL;
`ifdef LAST_TIME_EN
          last_n = '0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered state and outputs; lamp/flags follow the state being entered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      start_d    <= 1'b0;
      stop_d     <= 1'b0;
      BestTime   <= BCD_MAX;
      RoundCount <= '0;
      RandEn     <= 1'b1;
      CountClear <= 1'b1;
      CountEn    <= 1'b0;
      LED        <= 1'b0;
      Foul       <= 1'b0;
`ifdef LAST_TIME_EN
      LastTime   <= '0;
`endif
    end else begin
      state_q    <= state_n;
      wait_q     <= wait_n;
      start_d    <= Start;
      stop_d     <= Stop;
      BestTime   <= best_n;
      RoundCount <= rounds_n;
      RandEn     <= (state_n == IDLE);
      CountClear <= (state_n == IDLE) || (state_n == ARM);
      CountEn    <= count_en_n;
      LED        <= (state_n == GO);
      Foul       <= (state_n == FOUL);
`ifdef LAST_TIME_EN
      LastTime   <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_reaction_round_controller.sv
// Bench for reaction_round_controller: directed rounds plus random traffic, scoreboarded per clock.
// A decimal-arithmetic round model predicts every registered output one edge ahead.
module tb_reaction_round_controller;

  localparam int unsigned MIN_DELAY = 50;
  localparam int unsigned WAIT_W    = 8;
  localparam int P_IDLE = 0, P_ARM = 1, P_GO = 2, P_DONE = 3, P_FOUL = 4;

  logic        Clock = 1'b0;
  logic        Reset, Tick, Start, Stop;
  logic [6:0]  RandVal;
  logic [11:0] BcdIn;
  logic        RandEn, CountClear, CountEn, LED, Foul;
  logic [11:0] BestTime;
  logic [3:0]  RoundCount;
  logic [2:0]  State;
`ifdef LAST_TIME_EN
  logic [11:0] LastTime;
`endif

  reaction_round_controller #(.MIN_DELAY(MIN_DELAY), .WAIT_W(WAIT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .Stop(Stop),
    .RandVal(RandVal), .BcdIn(BcdIn), .RandEn(RandEn), .CountClear(CountClear),
    .CountEn(CountEn), .LED(LED), .Foul(Foul), .BestTime(BestTime),
    .RoundCount(RoundCount),
`ifdef LAST_TIME_EN
    .LastTime(LastTime),
`endif
    .State(State)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int   phase;
    bit   led, foul, rand_en, clr, cen;
    int   best_dec;
    int   rounds;
    int   last_dec;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Round model: remaining ticks, best time in decimal, valid-round tally.
  int m_phase, m_remain, m_best, m_rounds, m_last;
  bit m_cen, m_pstart, m_pstop;

  function automatic int bcd2dec(input logic [11:0] b);
    return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] dec2bcd(input int d);
    logic [11:0] r;
    r[11:8] = 4'(d / 100);
    r[7:4]  = 4'((d / 10) % 10);
    r[3:0]  = 4'(d % 10);
    return r;
  endfunction

  task automatic model_step(input bit rst, tick, start, stop, input int rv, input int bcd_dec);
    exp_t e;
    bit se, pe;
    if (rst) begin
      m_phase = P_IDLE; m_remain = 0; m_best = 999; m_rounds = 0; m_last = 0;
      m_cen = 0; m_pstart = 0; m_pstop = 0;
    end else begin
      se = start && !m_pstart;
      pe = stop && !m_pstop;
      m_cen = 0;
      case (m_phase)
        P_ARM: begin
          if (pe) m_phase = P_FOUL;
          else if (tick) begin
            m_remain--;
            if (m_remain == 0) m_phase = P_GO;
          end
        end
        P_GO: begin
          m_cen = tick && !pe;
          if (pe) begin
            m_phase = P_DONE;
            if (bcd_dec < m_best) m_best = bcd_dec;
            m_rounds = (m_rounds >= 15) ? 15 : m_rounds + 1;
            m_last = bcd_dec;
          end else if (tick && bcd_dec == 999) begin
            m_phase = P_FOUL;
            m_last = 0;
          end
        end
        default: begin
          if (se) begin
            m_phase = P_ARM;
            m_remain = int'(MIN_DELAY) + rv;
          end
        end
      endcase
      m_pstart = start;
      m_pstop = stop;
    end
    e.phase = m_phase;
    e.led = (m_phase == P_GO);
    e.foul = (m_phase == P_FOUL);
    e.rand_en = (m_phase == P_IDLE);
    e.clr = (m_phase == P_IDLE) || (m_phase == P_ARM);
    e.cen = m_cen;
    e.best_dec = m_best;
    e.rounds = m_rounds;
    e.last_dec = m_last;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: registered outputs settle after each edge; compare on the falling edge.
  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("State", 32'(State), 32'(e.phase));
      check("LED", 32'(LED), 32'(e.led));
      check("Foul", 32'(Foul), 32'(e.foul));
      check("RandEn", 32'(RandEn), 32'(e.rand_en));
      check("CountClear", 32'(CountClear), 32'(e.clr));
      check("CountEn", 32'(CountEn), 32'(e.cen));
      check("BestTime", 32'(BestTime), 32'(dec2bcd(e.best_dec)));
      check("RoundCount", 32'(RoundCount), 32'(e.rounds));
`ifdef LAST_TIME_EN
      check("LastTime", 32'(LastTime), 32'(dec2bcd(e.last_dec)));
`endif
    end
  end

  // Driver: apply one cycle of inputs, predict the post-edge outputs, advance one clock.
  task automatic cycle(input bit rst, tick, start, stop, input int rv, input int bcd_dec);
    Reset = rst; Tick = tick; Start = start; Stop = stop;
    RandVal = 7'(rv); BcdIn = dec2bcd(bcd_dec);
    model_step(rst, tick, start, stop, rv, bcd_dec);
    @(posedge Clock);
    #1;
  endtask

  task automatic press_start(input int rv);
    cycle(0, 0, 1, 0, rv, 0);
    cycle(0, 0, 0, 0, rv, 0);
  endtask

  task automatic tick_n(input int n, input int bcd_dec);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, bcd_dec);
  endtask

  task automatic run_round(input int rv, input int stop_dec);
    press_start(rv);
    tick_n(int'(MIN_DELAY) + rv, 0);
    tick_n(3, 1);
    cycle(0, 1, 0, 1, 0, stop_dec);
    cycle(0, 0, 0, 0, 0, stop_dec);
  endtask

  initial begin
    Reset = 1; Tick = 0; Start = 0; Stop = 0; RandVal = '0; BcdIn = '0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Round 1 with RandVal 10: lamp after exactly 60 ticks, stop at 234.
    run_round(10, 234);
    // False start after 5 ticks, then a fresh start clears Foul.
    press_start(3);
    tick_n(5, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    run_round(7, 300);
    for (int r = 0; r < 16; r++) run_round(int'($urandom_range(0, 127)), int'($urandom_range(0, 998)));
    // Timeout at 999.
    press_start(2);
    tick_n(int'(MIN_DELAY) + 2, 0);
    tick_n(2, 998);
    cycle(0, 1, 0, 0, 0, 999);
    cycle(0, 0, 0, 0, 0, 999);
    // Reset in GO.
    press_start(1);
    tick_n(int'(MIN_DELAY) + 1, 0);
    cycle(1, 1, 0, 0, 0, 5);
    cycle(0, 0, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
            int'($urandom_range(0, 127)),
            ($urandom_range(0, 15) == 0) ? 999 : int'($urandom_range(0, 998)));
    end
    @(negedge Clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_round_controller.md
Name: reaction_round_controller

Overview:
- Sequencing FSM for the reaction-timer datapath: LFSR random source, 10 ms tick prescaler, 3-digit BCD counter, LED.
- Runs one round per Start press: random wait, LED on, timing, then Stop.
- Detects false starts and timeouts, keeps the best time and a round count.
- Sits between the button inputs and the existing counter/display chain; it replaces the ad-hoc LED/enable glue.

Parameters:
MIN_DELAY, 50, minimum wait in ticks added to the random value (must be >= 1)
WAIT_W, 8, width of the internal wait counter; must hold MIN_DELAY+127

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
Tick  input  1  one-cycle enable pulse every 10 ms from the prescaler
Start  input  1  start button level, active-high, already synchronised
Stop  input  1  response button level, active-high, already synchronised
RandVal  input  7  current LFSR value
BcdIn  input  12  current BCD counter value {hundreds,tens,ones}
RandEn  output  1  advance LFSR
CountClear  output  1  synchronous clear to the BCD counter
CountEn  output  1  one-cycle increment enable to the BCD counter
LED  output  1  stimulus lamp
Foul  output  1  false start or timeout flag
BestTime  output  12  best valid BCD time so far
RoundCount  output  4  completed valid rounds, saturating
State  output  3  FSM state, debug

Behaviour:
- Reset is synchronous and active-high; the design has one clock, Clock.
- Reset values:
  - State=IDLE, LED=0, Foul=0, BestTime=12'h999, RoundCount=0, wait=0.
  - Edge-detect flops are 0.
- All outputs are registered; all decisions take effect on the next Clock edge.
- Edge detection:
  - startEdge = Start & ~Start_d; stopEdge = Stop & ~Stop_d.
  - Only rising edges matter; held levels are ignored.
- State encodings: IDLE=0, ARM=1, GO=2, DONE=3, FOUL=4.
- IDLE:
  - RandEn=1, CountClear=1.
  - On startEdge: go to ARM and load wait = MIN_DELAY + RandVal (zero-extended to WAIT_W).
- ARM:
  - CountClear=1, LED=0, RandEn=0.
  - On Tick: wait decrements. A Tick with wait==1 moves to GO, so the wait lasts MIN_DELAY+RandVal ticks.
  - On stopEdge: go to FOUL with Foul=1. This beats a simultaneous expiry.
  - startEdge is ignored.
- GO:
  - LED=1, CountEn=Tick.
  - On stopEdge: go to DONE. CountEn is forced to 0 that cycle even if Tick=1.
  - In DONE entry: if BcdIn < BestTime (a 12-bit unsigned compare is valid for BCD), BestTime<=BcdIn.
  - In DONE entry: RoundCount increments, saturating at 15.
  - On Tick with BcdIn==12'h999 and no stopEdge: go to FOUL with Foul=1 (timeout). BestTime and RoundCount are unchanged.
- DONE:
  - LED=0, CountEn=0. The BCD counter holds its value for display.
  - On startEdge: go to ARM (new round, wait reloaded).
- FOUL:
  - LED=0, Foul=1.
  - On startEdge: go to ARM with Foul<=0.
- Start and Stop edges in the same cycle: the Stop rules apply first; startEdge is ignored unless the state is IDLE, DONE or FOUL.
- Reset asserted mid-round: return to the reset values on the next edge. BestTime is restored to 999.

Optional Feature:
LAST_TIME_EN
- Defined:
  - Adds output LastTime[11:0], reset 12'h000.
  - Loaded with BcdIn on every GO->DONE transition.
  - Cleared to 12'h000 on GO->FOUL timeout.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
1. Reset held 2 cycles -> State=0, LED=0, Foul=0, BestTime=12'h999, RoundCount=0, RandEn=1, CountClear=1.
2. RandVal=7'd10, MIN_DELAY=50, Start rising -> ARM; LED rises the cycle after the 60th Tick, not after the 59th.
3. In ARM, Stop rising after 5 Ticks -> FOUL, Foul=1, LED=0, BestTime=999, RoundCount=0; next Start rising -> ARM, Foul=0.
4. Round 1: GO, BcdIn=12'h234, Stop rising -> DONE, BestTime=12'h234, RoundCount=1. Round 2: BcdIn=12'h300 -> BestTime stays 12'h234, RoundCount=2. Sixteen further valid rounds -> RoundCount=15.
5. In GO, BcdIn=12'h999 and Tick -> FOUL, Foul=1, BestTime unchanged.
6. In GO, Stop rising and Tick in the same cycle -> CountEn=0 that cycle, DONE. Separately, Reset asserted in GO -> IDLE and LED=0 after one edge.
